// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fixed fetch/decode, microword-driven EXEC with a 32-cycle watchdog.
// All outputs come from registers or registered state; stall freezes every register.
module micro_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        stall,
  input  logic [7:0]  IR,
  input  logic        zflag,
  input  logic [1:0]  mc_cond,
  input  logic [7:0]  mc_next,
  output logic [7:0]  CAR,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FETCH2 = 3'd3,
    DECODE = 3'd4,
    EXEC   = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  car_nx;
  logic [4:0]  xcnt, xcnt_nx;
  logic        err_nx;
  logic [15:0] cnt_nx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      CAR       <= 8'h00;
      xcnt      <= 5'd0;
      err       <= 1'b0;
      instr_cnt <= 16'h0000;
    end else if (!stall) begin
      state     <= state_nx;
      CAR       <= car_nx;
      xcnt      <= xcnt_nx;
      err       <= err_nx;
      instr_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    car_nx   = CAR;
    xcnt_nx  = xcnt;
    err_nx   = err;
    cnt_nx   = instr_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = FETCH0;
          car_nx   = 8'h00;
        end
      end
      FETCH0: begin state_nx = FETCH1; car_nx = 8'h01; end
      FETCH1: begin state_nx = FETCH2; car_nx = 8'h02; end
      FETCH2: begin state_nx = DECODE; car_nx = 8'h03; end
      DECODE: begin
        if (IR == 8'hFF) begin
          state_nx = HALT;
          car_nx   = 8'hFF;
        end else if (IR == 8'h00) begin
          cnt_nx   = instr_cnt + 16'd1;
          state_nx = FETCH0;
          car_nx   = 8'h00;
        end else if (IR[7:6] != 2'b00 || IR == 8'h3F) begin
          err_nx   = 1'b1;
          state_nx = FETCH0;
          car_nx   = 8'h00;
        end else begin
          state_nx = EXEC;
          car_nx   = {IR[5:0], 2'b00};
          xcnt_nx  = 5'd0;
        end
      end
      EXEC: begin
        xcnt_nx = xcnt + 5'd1;
        // xcnt==31 means this is the 32nd EXEC cycle; only an end-of-instruction may still retire
        if (xcnt == 5'd31 && mc_cond != 2'b11) begin
          err_nx   = 1'b1;
          state_nx = FETCH0;
          car_nx   = 8'h00;
        end else begin
          case (mc_cond)
            2'b00: car_nx = CAR + 8'd1;
            2'b01: car_nx = mc_next;
            2'b10: car_nx = zflag ? mc_next : CAR + 8'd1;
            default: begin
              cnt_nx   = instr_cnt + 16'd1;
              state_nx = FETCH0;
              car_nx   = 8'h00;
            end
          endcase
        end
      end
      HALT: state_nx = HALT;
      default: begin
        state_nx = IDLE;
        car_nx   = 8'h00;
      end
    endcase
  end

  assign phase  = state;
  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: hand-computed CAR/phase/flag values after each edge.
module tb_micro_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, stall, zflag;
  logic [7:0]  IR, mc_next;
  logic [1:0]  mc_cond;
  logic [7:0]  CAR;
  logic [2:0]  phase;
  logic        busy, halted, err;
  logic [15:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  micro_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stall(stall), .IR(IR),
    .zflag(zflag), .mc_cond(mc_cond), .mc_next(mc_next), .CAR(CAR),
    .phase(phase), .busy(busy), .halted(halted), .err(err), .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_car, input logic [2:0] e_ph,
                           input logic e_busy, input logic e_halt, input logic e_err,
                           input logic [15:0] e_cnt);
    check({tag, "_car"},   32'(CAR),       32'(e_car));
    check({tag, "_phase"}, 32'(phase),     32'(e_ph));
    check({tag, "_busy"},  32'(busy),      32'(e_busy));
    check({tag, "_halt"},  32'(halted),    32'(e_halt));
    check({tag, "_err"},   32'(err),       32'(e_err));
    check({tag, "_cnt"},   32'(instr_cnt), 32'(e_cnt));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // FETCH0 -> DECODE
  task automatic to_decode();
    tick(); tick(); tick();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; stall = 1'b0; zflag = 1'b0;
    IR = 8'h00; mc_next = 8'h00; mc_cond = 2'b00;
    #12;
    check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    RST_N = 1'b1;

    // start pulse and fetch sequence
    start = 1'b1; tick(); start = 1'b0;
    check_all("fetch0", 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 16'd0);
    tick(); check_all("fetch1", 8'h01, 3'd2, 1'b1, 1'b0, 1'b0, 16'd0);
    start = 1'b1;
    tick(); check_all("fetch2", 8'h02, 3'd3, 1'b1, 1'b0, 1'b0, 16'd0);
    start = 1'b0;
    tick(); check_all("decode", 8'h03, 3'd4, 1'b1, 1'b0, 1'b0, 16'd0);

    // IR=0x05: increment, increment, end
    IR = 8'h05; tick();
    check_all("exec05", 8'h14, 3'd5, 1'b1, 1'b0, 1'b0, 16'd0);
    mc_cond = 2'b00; tick(); check("exec05_inc1", 32'(CAR), 32'h15);
    tick(); check("exec05_inc2", 32'(CAR), 32'h16);
    mc_cond = 2'b11; tick();
    check_all("retire05", 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 16'd1);

    // IR=0x03, conditional jump taken
    to_decode(); IR = 8'h03; mc_cond = 2'b00; tick();
    check("exec03_entry", 32'(CAR), 32'h0C);
    mc_cond = 2'b10; mc_next = 8'h40; zflag = 1'b1; tick();
    check("jz_taken", 32'(CAR), 32'h40);
    mc_cond = 2'b11; tick();
    check("retire03a_cnt", 32'(instr_cnt), 32'd2);

    // IR=0x03, conditional jump not taken, then unconditional jump and wrap
    to_decode(); IR = 8'h03; mc_cond = 2'b00; tick();
    mc_cond = 2'b10; zflag = 1'b0; tick();
    check("jz_not_taken", 32'(CAR), 32'h0D);
    mc_cond = 2'b01; mc_next = 8'hFF; tick();
    check("jump_ff", 32'(CAR), 32'hFF);
    mc_cond = 2'b00; tick();
    check_all("car_wrap", 8'h00, 3'd5, 1'b1, 1'b0, 1'b0, 16'd2);
    mc_cond = 2'b11; tick();
    check("retire03b_cnt", 32'(instr_cnt), 32'd3);

    // watchdog with a stall window inside EXEC
    do_reset();
    check_all("reset2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    to_decode(); IR = 8'h02; mc_cond = 2'b00; tick();
    check("wd_entry", 32'(CAR), 32'h08);
    for (int i = 0; i < 10; i++) tick();
    check("wd_pre_stall", 32'(CAR), 32'h12);
    stall = 1'b1; start = 1'b1;
    tick(); tick(); tick();
    check_all("wd_stalled", 8'h12, 3'd5, 1'b1, 1'b0, 1'b0, 16'd0);
    stall = 1'b0; start = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    check_all("wd_cycle32", 8'h27, 3'd5, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_all("wd_fire", 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 16'd0);

    // asynchronous reset mid-EXEC while stalled
    to_decode(); IR = 8'h05; tick();
    check("async_pre", 32'(phase), 32'd5);
    stall = 1'b1; tick();
    RST_N = 1'b0; #1;
    check_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    #1; RST_N = 1'b1; stall = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("start_after_rst", 32'(phase), 32'd1);

    // NOP, illegal, halt
    to_decode(); IR = 8'h00; tick();
    check_all("nop", 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 16'd1);
    to_decode(); IR = 8'h80; tick();
    check_all("illegal80", 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 16'd1);
    to_decode(); IR = 8'hFF; tick();
    check_all("halt", 8'hFF, 3'd6, 1'b0, 1'b1, 1'b1, 16'd1);
    start = 1'b1; tick(); tick(); start = 1'b0;
    check_all("halt_hold", 8'hFF, 3'd6, 1'b0, 1'b1, 1'b1, 16'd1);
    do_reset();
    check_all("halt_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);

    // IR=0x3F is illegal despite a zero top field
    start = 1'b1; tick(); start = 1'b0;
    to_decode(); IR = 8'h3F; tick();
    check_all("illegal3f", 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; leaves IDLE.
REQ-005 stall  input  1  memory wait; freezes all registers while 1.
REQ-006 IR  input  8  instruction register contents (opcode).
REQ-007 zflag  input  1  ALU zero flag.
REQ-008 mc_cond  input  2  next-address control field of the current microword: 00 increment, 01 jump, 10 jump if zflag, 11 end of instruction.
REQ-009 mc_next  input  8  branch target field of the current microword.
REQ-010 CAR  output  8  registered control-memory address.
REQ-011 phase  output  3  registered state code.
REQ-012 busy  output  1  1 in every state except IDLE and HALT.
REQ-013 halted  output  1  1 in HALT.
REQ-014 err  output  1  sticky error flag.
REQ-015 instr_cnt  output  16  count of retired instructions.

Function
REQ-016 States and phase codes SHALL be IDLE=0, FETCH0=1, FETCH1=2, FETCH2=3, DECODE=4, EXEC=5, HALT=6.
REQ-017 CAR SHALL be 0x00 in IDLE, 0x00/0x01/0x02 in FETCH0/1/2, 0x03 in DECODE and 0xFF in HALT.
REQ-018 IDLE with start=1 SHALL go to FETCH0 next cycle; start SHALL be ignored in all other states.
REQ-019 FETCH0 -> FETCH1 -> FETCH2 -> DECODE SHALL each take one cycle.
REQ-020 IR SHALL be sampled on the edge that leaves DECODE, and that decision SHALL apply as follows:
- IR=0xFF: go to HALT.
- IR=0x00 (NOP): instr_cnt+1, go to FETCH0.
- IR[7:6]!=00 (other than 0xFF), or IR=0x3F: illegal; set err=1, go to FETCH0, instr_cnt unchanged.
- Otherwise: go to EXEC with CAR={IR[5:0],2'b00}.
REQ-021 In EXEC, the next CAR and state SHALL follow mc_cond:
- 00: CAR+1, wrapping 0xFF->0x00, stay in EXEC.
- 01: CAR=mc_next.
- 10: CAR=mc_next if zflag=1, else CAR+1.
- 11: instr_cnt+1, go to FETCH0.
REQ-022 A 5-bit exec-cycle counter SHALL clear on entry to EXEC and count each unstalled EXEC cycle.
REQ-023 On the 32nd EXEC cycle without mc_cond=11, the block SHALL set err=1 and go to FETCH0 instead of following mc_cond, with instr_cnt unchanged.
REQ-024 While stall=1, state, CAR, counters and err SHALL hold, and start SHALL be ignored.
REQ-025 HALT SHALL be left only by reset.
REQ-026 instr_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-027 err SHALL be cleared only by reset.
REQ-028 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-029 When RST_N=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, CAR=0x00, phase=0, busy=0, halted=0, err=0, instr_cnt=0 and exec counter=0, including in the middle of an operation.
REQ-030 Reset SHALL take priority over stall and start.
REQ-031 The first rising edge after RST_N returns to 1 SHALL be able to accept start.

Verification
REQ-032 Reset then start pulse -> CAR 0x00,0x01,0x02,0x03 on successive cycles, phase 1..4, busy=1.
REQ-033 IR=0x05, mc_cond 00,00,11 -> CAR 0x14,0x15,0x16 then 0x00 (FETCH0), instr_cnt=1.
REQ-034 IR=0x03, mc_cond=10, mc_next=0x40: zflag=1 -> CAR 0x40; zflag=0 -> CAR 0x0D.
REQ-035 IR=0x80 -> err=1, next CAR=0x00, instr_cnt unchanged; then IR=0xFF -> halted=1, CAR=0xFF, start ignored until RST_N pulse clears all.
REQ-036 IR=0x02 with mc_cond held 00 for 32 EXEC cycles -> err=1, FETCH0; stall=1 during EXEC holds CAR and the watchdog for the stalled cycles.
REQ-037 RST_N asserted mid-EXEC with stall=1 -> outputs at reset values before the next clock edge.
